// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states, address map, timing defaults,
// and the execute-command and opcode encodings used across the pipeline.
package sram_controller_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } sram_state_t;

    localparam int unsigned SRAM_BASE_ADDR   = 1024;
    localparam int unsigned SRAM_WAIT_CYCLES = 2;

    typedef enum logic [3:0] {
        EXE_NOP = 4'd0,
        EXE_MOV = 4'd1,
        EXE_ADD = 4'd2,
        EXE_SUB = 4'd3,
        EXE_AND = 4'd4,
        EXE_ORR = 4'd5,
        EXE_LDR = 4'd6,
        EXE_STR = 4'd7
    } exe_cmd_t;

    typedef enum logic [3:0] {
        OP_MOV = 4'b1101,
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0010,
        OP_AND = 4'b0000,
        OP_ORR = 4'b1100
    } opcode_t;

    // Byte address to 32-bit SRAM word index; the upper bits fall off the 17-bit index.
    function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the SRAM controller (slave).
// Requests are level-held by the master until it sees ready high.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store onto a 16-bit async SRAM as two half-word cycles (low half, then high half).
// Latency 4+WAIT_CYCLES cycles from request to ready; ready is low while an access runs.
// Backpressure: ready low freezes the pipeline, which must hold its request until ready is high.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   mem,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

    sram_state_t state;
    logic [2:0]  wait_cnt;
    logic        is_write;
    logic [31:0] read_data_q;
    logic        req;
    logic [16:0] idx;

    assign req = mem.wr_en | mem.rd_en;
    assign idx = word_index(mem.address, 32'(BASE_ADDR));

    assign mem.ready     = (state == DONE) || ((state == IDLE) && !req);
    assign mem.read_data = read_data_q;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign SRAM_DQ = (is_write && ((state == LO) || (state == HI)))
                   ? ((state == LO) ? mem.write_data[15:0] : mem.write_data[31:16])
                   : 16'hzzzz;

    // Address and strobe are registered one state ahead so they are valid for the whole LO/HI cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            is_write    <= 1'b0;
            read_data_q <= 32'd0;
            SRAM_ADDR   <= 18'd0;
            SRAM_WE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= LO;
                        is_write  <= mem.wr_en;
                        SRAM_ADDR <= {idx, 1'b0};
                        SRAM_WE_N <= ~mem.wr_en;
                    end
                end
                LO: begin
                    state     <= HI;
                    SRAM_ADDR <= {idx, 1'b1};
                    if (!is_write) read_data_q[15:0] <= SRAM_DQ;
                end
                HI: begin
                    state     <= WAIT;
                    wait_cnt  <= 3'd0;
                    SRAM_ADDR <= 18'd0;
                    SRAM_WE_N <= 1'b1;
                    if (!is_write) read_data_q[31:16] <= SRAM_DQ;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed plus randomized bench for sram_controller against a word-level reference memory
// and a per-cycle access schedule; an async SRAM model sits on the external bus.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int unsigned BASE = 1024;
    localparam int unsigned WC   = 2;
    localparam int          LAT  = 4 + WC;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    sram_controller_if bus ();

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus.slave),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Async SRAM with OE/CE tied active: drives the bus whenever it is not being written.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access, checked cycle by cycle: k=1 is the IDLE cycle with the request,
    // k=2 drives the low half, k=3 the high half, k=LAT is DONE.
    task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        int          idx;
        logic [31:0] word;
        logic [31:0] exp_dq;
        idx  = int'((addr - BASE) >> 2);
        word = wr ? wdata : (ref_mem.exists(idx) ? ref_mem[idx] : 32'd0);
        @(negedge clk);
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = wr ? wdata : ~word;
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            check($sformatf("ready a=%0d k=%0d", addr, k), 32'(bus.ready), 32'(k == LAT));
            check($sformatf("sram_addr a=%0d k=%0d", addr, k), 32'(sram_addr),
                  (k == 2) ? 32'(idx * 2) : (k == 3) ? 32'(idx * 2 + 1) : 32'd0);
            check($sformatf("we_n a=%0d k=%0d", addr, k), 32'(sram_we_n),
                  (wr && (k == 2 || k == 3)) ? 32'd0 : 32'd1);
            if (k == 2 || k == 3) begin
                exp_dq = (k == 2) ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
                check($sformatf("dq a=%0d k=%0d", addr, k), 32'(sram_dq), exp_dq);
            end
        end
        if (wr) ref_mem[idx] = wdata;
        else    ref_rd = word;
        check($sformatf("read_data a=%0d", addr), bus.read_data, ref_rd);
        if (!hold) begin
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int          idx;
        bit          wr, rd;

        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = BASE;
        bus.write_data = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst sram_addr", 32'(sram_addr), 32'd0);
        check("rst we_n", 32'(sram_we_n), 32'd1);
        check("rst read_data", bus.read_data, 32'd0);
        check("tied strobes", {28'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("ready after rst", 32'(bus.ready), 32'd1);

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
        check("readback 1024", bus.read_data, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1032, 32'hA5A55A5A, 1'b0);
        access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        access(1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b0);
        check("both held read_data", bus.read_data, 32'hA5A55A5A);
        access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0);
        check("readback 1028", bus.read_data, 32'h12345678);

        // Request left high across DONE runs straight into a second access.
        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b1);
        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            idx = int'($urandom_range(0, 15));
            a   = BASE + 32'(idx * 4);
            wr  = ($urandom_range(0, 1) == 1) || !ref_mem.exists(idx);
            rd  = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            d   = $urandom;
            access(wr, rd, a, d, 1'b0);
        end

        // Reset during the high half of a write aborts it.
        a = BASE + 32'd240;
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = a;
        bus.write_data = $urandom;
        repeat (2) @(negedge clk);
        #1;
        check("we_n in HI before rst", 32'(sram_we_n), 32'd0);
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        #1;
        check("abort ready", 32'(bus.ready), 32'd1);
        check("abort we_n", 32'(sram_we_n), 32'd1);
        check("abort sram_addr", 32'(sram_addr), 32'd0);
        check("abort read_data", bus.read_data, 32'd0);
        check("abort dq released", 32'(sram_dq), {16'd0, ref_mem[0][15:0]});
        ref_rd = 32'd0;
        rst    = 1'b0;
        @(negedge clk);
        #1;
        check("idle after abort", 32'(bus.ready), 32'd1);
        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, 1024, byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter WAIT_CYCLES, 2, idle cycles after the high-half access, range 1..7.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  in  1  memory write request from the MEM stage (MEM_W_EN).
REQ-006 SHALL have port rd_en  in  1  memory read request from the MEM stage (MEM_R_EN).
REQ-007 SHALL have port address  in  32  byte address from the ALU result, word-aligned.
REQ-008 SHALL have port write_data  in  32  store data.
REQ-009 SHALL have port read_data  out  32  load data, registered.
REQ-010 SHALL have port ready  out  1  high means no access in progress; low freezes the pipeline.
REQ-011 SHALL have port SRAM_DQ  inout  16  external SRAM data bus.
REQ-012 SHALL have port SRAM_ADDR  out  18  external SRAM half-word address.
REQ-013 SHALL have port SRAM_WE_N  out  1  external write strobe, active-low.
REQ-014 SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each, tied constant 0.

Function
REQ-015 SHALL implement FSM states IDLE, LO, HI, WAIT, DONE.
REQ-016 IDLE SHALL go to LO when wr_en or rd_en is high; otherwise it SHALL stay in IDLE.
REQ-017 LO SHALL go to HI, and HI SHALL go to WAIT.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 3-bit counter cleared on entry, and SHALL then go to DONE.
REQ-019 DONE SHALL go to IDLE unconditionally.
REQ-020 ready SHALL be combinational: 0 in IDLE with any request present, 0 in LO/HI/WAIT, and 1 in DONE and in IDLE with no request.
REQ-021 Total latency SHALL be 4+WAIT_CYCLES cycles; the default is 6, with ready low for 5 cycles and high in the 6th.
REQ-022 The requester SHALL hold address, write_data, rd_en and wr_en stable until it samples ready high; the block SHALL NOT latch them.
REQ-023 Word index SHALL be (address - BASE_ADDR) >> 2, truncated to 17 bits.
REQ-024 SRAM_ADDR SHALL be {index,0} in LO and {index,1} in HI, and 0 elsewhere.
REQ-025 Write: SRAM_WE_N SHALL be 0 in LO and HI only, and 1 in all other states.
REQ-026 Write: SRAM_DQ SHALL carry write_data[15:0] in LO and write_data[31:16] in HI, and be high-Z otherwise.
REQ-027 Read: SRAM_DQ SHALL be high-Z throughout the access.
REQ-028 Read: read_data[15:0] SHALL load SRAM_DQ at the LO->HI edge, and read_data[31:16] SHALL load at the HI->WAIT edge.
REQ-029 read_data SHALL hold its value through writes and idle cycles.
REQ-030 If wr_en and rd_en are both high, the access SHALL be a write and read_data SHALL be unchanged.
REQ-031 If a request is still high in IDLE after DONE, a new access SHALL start; back-to-back accesses SHALL be separated only by the IDLE cycle.
REQ-032 The access type SHALL be captured on the IDLE->LO edge into a registered is_write flag; request changes mid-access SHALL be ignored.

Reset
REQ-033 At a clock edge with rst high, state SHALL become IDLE, the wait counter 0, is_write 0, read_data 0, SRAM_ADDR 0, SRAM_WE_N 1 and SRAM_DQ high-Z.
REQ-034 Reset during any state, including a write in LO/HI, SHALL abort the access with no further SRAM strobes; a partial SRAM write is accepted.
REQ-035 ready SHALL be 1 in the first cycle after reset if no request is present.

Structure
REQ-036 State encoding, BASE_ADDR and the default WAIT_CYCLES SHALL live in the shared definitions package alongside the exe_cmd/opcode constants.
REQ-037 The block SHALL be a single module with no sub-module; the wait counter SHALL be inline.
REQ-038 The SRAM_DQ tri-state SHALL be a single continuous assignment gated by is_write and state in {LO,HI}.

Verification
REQ-039 The bench SHALL cover: write, address=1024, data=0xDEADBEEF -> SRAM_ADDR 0 then 1, DQ 0xBEEF then 0xDEAD, WE_N low 2 cycles, ready high in cycle 6.
REQ-040 The bench SHALL cover: read, address=1024, after the above with an SRAM model -> read_data=0xDEADBEEF, DQ high-Z, WE_N stays 1.
REQ-041 The bench SHALL cover: read, address=1032 -> SRAM_ADDR 4 then 5, ready low exactly 5 cycles.
REQ-042 The bench SHALL cover: rd_en=wr_en=1, address=1028, data=0x12345678 -> write to SRAM_ADDR 2/3, read_data unchanged.
REQ-043 The bench SHALL cover: rst asserted in HI of a write -> next cycle IDLE, WE_N=1, DQ high-Z, read_data=0.
REQ-044 The bench SHALL cover: request held across DONE -> second access begins after one IDLE cycle, ready high only in the two DONE cycles.
